lcd_console: RTL and testbench
==============================

# lcd_console

Parametrised text-console front end for the HD44780 character LCD. It buffers characters from a producer in an internal FIFO and tracks a cursor (row, column) for a configurable panel geometry. It interprets control characters, wraps long lines, and issues `wr_cmd`/`wr_char` requests to the `lcd_hd44780` driver instantiated beside it at top level.

## Interface
- `FIFO_DEPTH`, 16 — character buffer entries; power of two, 2..256.
- `COLS`, 16 — visible columns; 8..40.
- `ROWS`, 2 — visible rows; 1, 2 or 4.
- `WRAP_MODE`, 0 — on row overflow: 0 returns to row 0 without clearing; 1 clears the display, then returns to row 0.
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `char` in 8 — character to print.
- `print` in 1 — write strobe; `char` is accepted on any edge where `print=1` and `busy=0`.
- `busy` out 1 — FIFO full.
- `idle` out 1 — FIFO empty, FSM in IDLE, and no request outstanding.
- `overflow` out 1 — sticky; set by `print=1` while `busy=1`; cleared only by reset.
- `cursor_row` out $clog2(ROWS) or 1 — current row.
- `cursor_col` out $clog2(COLS+1) — current column; the value COLS means "line full, wrap pending".
- `lcd_data` out 8 — byte sent to the driver.
- `lcd_wr_cmd` out 1 — one-cycle command request.
- `lcd_wr_char` out 1 — one-cycle data-write request.
- `lcd_busy` in 1 — driver busy.
- `lcd_initialized` in 1 — driver has finished its init sequence.

## Operation
- **Reset values:** `busy=0`, `idle=1`, `overflow=0`, cursor 0/0, `lcd_data=0x00`, `lcd_wr_cmd=0`, `lcd_wr_char=0`, FIFO empty, FSM in IDLE.
- **Row base addresses:** row0 `0x00`, row1 `0x40`, row2 `COLS`, row3 `0x40+COLS`. A set-address command is `0x80 | (base + col)`.
- **FSM states:**
  - IDLE: go to FETCH when the FIFO is non-empty and `lcd_initialized=1`.
  - FETCH: assert FIFO read for one cycle.
  - DECODE: FIFO data is valid here; latch it and select the next operation.
  - ISSUE: pulse the request for one cycle.
  - WAIT_ACK: wait for `lcd_busy=1`.
  - WAIT_DONE: wait for `lcd_busy=0`. Then return to DECODE if a second operation is pending for the latched char; otherwise go to IDLE, or straight to FETCH if the FIFO is non-empty.
  - ISSUE is entered only when `lcd_busy=0`.
- **Decode rules:**
  - `0x20..0x7E`: if `col==COLS`, first issue set-address for the next row, col 0 (applying the row-overflow rule), then write the char. Otherwise write the char. After a write, `col` increments.
  - `0x0A` (`\n`): move to the next row, col 0, with one set-address command. A pending wrap does not produce an extra row.
  - `0x0D` (`\r`): col←0; set-address on the same row.
  - `0x08` (`\b`): if `col>0`, col−1 and set-address. At col 0, no command is issued and the char is consumed.
  - `0x0C` (`\f`): command `0x01` (clear); cursor←0/0.
  - Any other byte: write `0x20` (space) and treat it as printable.
- **Row overflow** (next row would be `ROWS`):
  - `WRAP_MODE=0`: row←0.
  - `WRAP_MODE=1`: issue `0x01`, then set-address `0x80`; row←0, col←0.
- **Cursor update:** the cursor updates in the cycle the corresponding request is pulsed.
- **`lcd_initialized` low mid-stream:** the current operation completes; no new FETCH occurs until `lcd_initialized` returns high. The FIFO keeps its contents.

## Timing
- **Write acceptance:** a write at edge N makes `busy` reflect the new fill level after edge N. A read and a write in the same cycle leave the fill level unchanged. A write while full is dropped and sets `overflow`.
- **Latency:** with the driver idle and initialized, and the FSM in IDLE, a printable char accepted at edge N produces `lcd_wr_char=1` during the cycle after edge N+3, for exactly one cycle, with `lcd_data` valid in that same cycle.
- **Request hold:** `lcd_data` is held from ISSUE until WAIT_DONE exits.
- **Two-operation chars** (wrap + write, clear + address): the second request follows the first by at least the driver's busy period plus one cycle.
- **Asynchronous reset:** `rst_n` low at any time forces all reset values immediately, including mid-request; an in-flight request is abandoned.

## Structure
- Package `lcd_pkg`:
  - control-char constants (`LF`, `CR`, `BS`, `FF`, `SPACE`);
  - command constants (`CMD_CLEAR=0x01`, `CMD_SETADDR=0x80`);
  - the FSM state enum;
  - a `row_base(row, cols)` function.
- Sub-module `lcd_console_fifo`: synchronous FIFO with asynchronous active-low reset, one-cycle read latency, and `full`/`empty` flags. It is parametrised by `FIFO_DEPTH` with 8-bit data.

## Test plan
- **Basic print:** reset, then print "AB" with `COLS=16`. Expect `wr_char` with `0x41`, then `0x42`; cursor ends at 0/2; first pulse 3 cycles after acceptance.
- **Auto-wrap:** 17 × 'x' with `COLS=16`, `ROWS=2`. Expect 16 writes, then cmd `0xC0`, then 'x'; cursor ends at 1/1.
- **Control chars:** "ab\rc\n\bZ\x0C". Expect cmd `0x80`, write 'c', cmd `0xC0`, no cmd for `\b`, write 'Z', cmd `0x01`; cursor ends at 0/0.
- **Row overflow:** `ROWS=2`, `WRAP_MODE=1`, send "\n\n". Expect `0xC0`, then `0x01` followed by `0x80`. With `WRAP_MODE=0`, expect `0xC0`, `0x80`.
- **Full FIFO:** `FIFO_DEPTH=4`, hold `lcd_busy=1`, push 6 chars. Expect `busy` high after 4 accepted, 2 dropped, `overflow=1`; the 4 chars drain in order after `lcd_busy` falls.
- **Reset mid-operation:** pulse `rst_n` low during WAIT_ACK with the FIFO non-empty. Expect outputs at reset values immediately, `idle=1`, and no further requests.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, FSM states and row address helper for the LCD console
package lcd_pkg;

   localparam logic [7:0] LF    = 8'h0A;
   localparam logic [7:0] CR    = 8'h0D;
   localparam logic [7:0] BS    = 8'h08;
   localparam logic [7:0] FF    = 8'h0C;
   localparam logic [7:0] SPACE = 8'h20;

   localparam logic [7:0] CMD_CLEAR   = 8'h01;
   localparam logic [7:0] CMD_SETADDR = 8'h80;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_ISSUE,
      S_WAIT_ACK,
      S_WAIT_DONE
   } state_t;

   // Which step of a multi-request character comes next.
   typedef enum logic [1:0] {
      PH_FIRST,
      PH_ADDR0,
      PH_WRITE
   } phase_t;

   // DDRAM base address of a visible row; rows 2/3 continue rows 0/1.
   function automatic logic [7:0] row_base(input logic [1:0] row, input logic [7:0] cols);
      case (row)
         2'd0:    row_base = 8'h00;
         2'd1:    row_base = 8'h40;
         2'd2:    row_base = cols;
         default: row_base = 8'h40 + cols;
      endcase
   endfunction

endpackage

// File: rtl/lcd_console_fifo.sv
// rtl/lcd_console_fifo.sv - character buffer with registered read data and full/empty flags
module lcd_console_fifo #(
   parameter int DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       rd_en,
   output logic [7:0] rd_data,
   output logic       full,
   output logic       empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_wr;
   logic          do_rd;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   // Storage array; no reset needed, the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   // Pointers, fill level and the one-cycle-latency read register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= 8'h00;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rd_data <= mem[rd_ptr];
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/lcd_console.sv
// rtl/lcd_console.sv - text console front end issuing HD44780 driver requests
module lcd_console
   import lcd_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int COLS       = 16,
   parameter int ROWS       = 2,
   parameter int WRAP_MODE  = 0
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [7:0]                              char,
   input  logic                                    print,
   output logic                                    busy,
   output logic                                    idle,
   output logic                                    overflow,
   output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] cursor_row,
   output logic [$clog2(COLS + 1)-1:0]             cursor_col,
   output logic [7:0]                              lcd_data,
   output logic                                    lcd_wr_cmd,
   output logic                                    lcd_wr_char,
   input  logic                                    lcd_busy,
   input  logic                                    lcd_initialized
);
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int COL_W = $clog2(COLS + 1);
   localparam logic [COL_W-1:0] COL_FULL = COL_W'(COLS);
   localparam logic [ROW_W:0]   ROW_LIM  = (ROW_W + 1)'(ROWS);

   state_t           state;
   state_t           state_nxt;
   phase_t           phase;
   logic [7:0]       cur_char;
   logic             fifo_rd;
   logic [7:0]       fifo_rdata;
   logic             fifo_full;
   logic             fifo_empty;
   logic             can_fetch;

   // Request latched when leaving DECODE, applied to the cursor in ISSUE.
   logic             op_cmd;
   logic [ROW_W-1:0] op_row;
   logic [COL_W-1:0] op_col;
   phase_t           op_next;

   // Decoder outputs.
   logic [7:0]       dchar;
   logic             is_ctrl;
   logic [7:0]       wchar;
   logic [ROW_W:0]   row_inc;
   logic             row_wraps;
   logic [ROW_W-1:0] next_row;
   logic             do_write;
   logic             do_wrap;
   logic             d_valid;
   logic             d_cmd;
   logic [7:0]       d_data;
   logic [ROW_W-1:0] d_row;
   logic [COL_W-1:0] d_col;
   phase_t           d_next;

   function automatic logic [7:0] set_addr(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
      return CMD_SETADDR | (row_base(2'(r), 8'(COLS)) + 8'(c));
   endfunction

   lcd_console_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (print),
      .wr_data (char),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign busy      = fifo_full;
   assign idle      = fifo_empty && (state == S_IDLE);
   assign can_fetch = !fifo_empty && lcd_initialized;

   // Sticky flag for a write attempted while the buffer was full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) overflow <= 1'b0;
      else if (print && fifo_full) overflow <= 1'b1;
   end

   // Decide the next request for the current character and cursor.
   always_comb begin
      dchar     = (phase == PH_FIRST) ? fifo_rdata : cur_char;
      is_ctrl   = (dchar == LF) || (dchar == CR) || (dchar == BS) || (dchar == FF);
      wchar     = ((dchar >= 8'h20) && (dchar <= 8'h7E)) ? dchar : SPACE;
      row_inc   = {1'b0, cursor_row} + 1'b1;
      row_wraps = (row_inc >= ROW_LIM);
      next_row  = row_wraps ? '0 : row_inc[ROW_W-1:0];
      do_write  = 1'b0;
      do_wrap   = 1'b0;
      d_valid   = 1'b1;
      d_cmd     = 1'b1;
      d_data    = CMD_CLEAR;
      d_row     = cursor_row;
      d_col     = cursor_col;
      d_next    = PH_FIRST;
      if (phase == PH_ADDR0) begin
         d_data = CMD_SETADDR;
         d_row  = '0;
         d_col  = '0;
         d_next = is_ctrl ? PH_FIRST : PH_WRITE;
      end else if (phase == PH_WRITE) begin
         do_write = 1'b1;
      end else begin
         case (dchar)
            LF: do_wrap = 1'b1;
            CR: begin
               d_data = set_addr(cursor_row, '0);
               d_col  = '0;
            end
            BS: begin
               if (cursor_col != '0) begin
                  d_col  = cursor_col - 1'b1;
                  d_data = set_addr(cursor_row, cursor_col - 1'b1);
               end else begin
                  d_valid = 1'b0;
               end
            end
            FF: begin
               d_row = '0;
               d_col = '0;
            end
            default: begin
               if (cursor_col < COL_FULL) do_write = 1'b1;
               else                       do_wrap  = 1'b1;
            end
         endcase
      end
      if (do_write) begin
         d_cmd  = 1'b0;
         d_data = wchar;
         d_col  = cursor_col + 1'b1;
         d_next = PH_FIRST;
      end
      if (do_wrap) begin
         if (row_wraps && (WRAP_MODE != 0)) begin
            d_data = CMD_CLEAR;
            d_row  = '0;
            d_col  = '0;
            d_next = PH_ADDR0;
         end else begin
            d_data = set_addr(next_row, '0);
            d_row  = next_row;
            d_col  = '0;
            d_next = is_ctrl ? PH_FIRST : PH_WRITE;
         end
      end
   end

   // Sequencer next state, FIFO read strobe and request pulses.
   always_comb begin
      state_nxt   = state;
      fifo_rd     = 1'b0;
      lcd_wr_cmd  = (state == S_ISSUE) && op_cmd;
      lcd_wr_char = (state == S_ISSUE) && !op_cmd;
      case (state)
         S_IDLE:      if (can_fetch) state_nxt = S_FETCH;
         S_FETCH: begin
            fifo_rd   = 1'b1;
            state_nxt = S_DECODE;
         end
         S_DECODE: begin
            if (!d_valid)      state_nxt = can_fetch ? S_FETCH : S_IDLE;
            else if (!lcd_busy) state_nxt = S_ISSUE;
         end
         S_ISSUE:     state_nxt = S_WAIT_ACK;
         S_WAIT_ACK:  if (lcd_busy) state_nxt = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (!lcd_busy) begin
               if (phase != PH_FIRST) state_nxt = S_DECODE;
               else                   state_nxt = can_fetch ? S_FETCH : S_IDLE;
            end
         end
         default:     state_nxt = S_IDLE;
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Latch char and request, then commit cursor and phase as the request pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase      <= PH_FIRST;
         cur_char   <= 8'h00;
         cursor_row <= '0;
         cursor_col <= '0;
         op_cmd     <= 1'b0;
         lcd_data   <= 8'h00;
         op_row     <= '0;
         op_col     <= '0;
         op_next    <= PH_FIRST;
      end else begin
         if ((state == S_DECODE) && (phase == PH_FIRST)) cur_char <= fifo_rdata;
         if ((state == S_DECODE) && (state_nxt == S_ISSUE)) begin
            op_cmd   <= d_cmd;
            lcd_data <= d_data;
            op_row   <= d_row;
            op_col   <= d_col;
            op_next  <= d_next;
         end
         if (state == S_ISSUE) begin
            cursor_row <= op_row;
            cursor_col <= op_col;
            phase      <= op_next;
         end
      end
   end

endmodule

// File: tb/tb_lcd_console.sv
// tb/tb_lcd_console.sv - directed self-checking bench for lcd_console
module tb_lcd_console;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] ch = 8'h00;
   logic       print0 = 1'b0;
   logic       print1 = 1'b0;
   logic       init = 1'b1;
   logic       hold = 1'b0;

   logic       busy0, idle0, ovf0, wc0, wd0, lb0, b0;
   logic       busy1, idle1, ovf1, wc1, wd1, lb1, b1;
   logic [0:0] row0, row1;
   logic [4:0] col0, col1;
   logic [7:0] data0, data1;
   int         c0, c1;
   logic [8:0] log0[$];
   logic [8:0] log1[$];
   logic [8:0] exp_q[$];
   logic [7:0] ctl_str [8] = '{8'h61, 8'h62, 8'h0D, 8'h63, 8'h0A, 8'h08, 8'h5A, 8'h0C};

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   assign lb0 = b0 | hold;
   assign lb1 = b1 | hold;

   lcd_console #(.FIFO_DEPTH(4), .COLS(16), .ROWS(2), .WRAP_MODE(0)) u0 (
      .clk(clk), .rst_n(rst_n), .char(ch), .print(print0), .busy(busy0), .idle(idle0),
      .overflow(ovf0), .cursor_row(row0), .cursor_col(col0), .lcd_data(data0),
      .lcd_wr_cmd(wc0), .lcd_wr_char(wd0), .lcd_busy(lb0), .lcd_initialized(init)
   );

   lcd_console #(.FIFO_DEPTH(4), .COLS(16), .ROWS(2), .WRAP_MODE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .char(ch), .print(print1), .busy(busy1), .idle(idle1),
      .overflow(ovf1), .cursor_row(row1), .cursor_col(col1), .lcd_data(data1),
      .lcd_wr_cmd(wc1), .lcd_wr_char(wd1), .lcd_busy(lb1), .lcd_initialized(init)
   );

   // Driver models: log each request, then stay busy for three cycles.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b0 <= 1'b0; c0 <= 0;
      end else if (wc0 || wd0) begin
         log0.push_back({wc0, data0}); b0 <= 1'b1; c0 <= 3;
      end else if (c0 > 0) begin
         c0 <= c0 - 1; if (c0 == 1) b0 <= 1'b0;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b1 <= 1'b0; c1 <= 0;
      end else if (wc1 || wd1) begin
         log1.push_back({wc1, data1}); b1 <= 1'b1; c1 <= 3;
      end else if (c1 > 0) begin
         c1 <= c1 - 1; if (c1 == 1) b1 <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_log(input string tag, input logic [8:0] got[$], input logic [8:0] exp[$]);
      chk({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
      foreach (exp[i])
         chk($sformatf("%s[%0d]", tag, i), 32'((i < got.size()) ? got[i] : 9'h1FF), 32'(exp[i]));
   endtask

   task automatic push(input bit which, input logic [7:0] c);
      int t = 0;
      while ((which ? busy1 : busy0) && t < 500) begin @(posedge clk); #1; t++; end
      if (t >= 500) chk("push_timeout", 32'(t), 0);
      ch = c;
      if (which) print1 = 1'b1; else print0 = 1'b1;
      @(posedge clk); #1;
      print0 = 1'b0; print1 = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      while (!(idle0 && idle1) && t < 3000) begin @(posedge clk); #1; t++; end
      chk({tag, "_idle"}, 32'(idle0 && idle1), 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      log0.delete(); log1.delete();
      @(posedge clk); #1;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk); #1;
      chk("rst_busy", 32'(busy0), 0);
      chk("rst_idle", 32'(idle0), 1);
      chk("rst_ovf", 32'(ovf0), 0);
      chk("rst_row", 32'(row0), 0);
      chk("rst_col", 32'(col0), 0);
      chk("rst_data", 32'(data0), 0);
      chk("rst_wr_cmd", 32'(wc0), 0);
      chk("rst_wr_char", 32'(wd0), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic print with latency of the first request
      ch = 8'h41; print0 = 1'b1;
      @(posedge clk); #1; print0 = 1'b0;
      @(posedge clk); #1; chk("lat_n1", 32'(wd0), 0);
      @(posedge clk); #1; chk("lat_n2", 32'(wd0), 0);
      @(posedge clk); #1; chk("lat_n3_wr", 32'(wd0), 1); chk("lat_n3_data", 32'(data0), 32'h41);
      @(posedge clk); #1; chk("lat_n4_wr", 32'(wd0), 0); chk("hold_data", 32'(data0), 32'h41);
      push(0, 8'h42);
      wait_idle("basic");
      exp_q = '{9'h041, 9'h042};
      check_log("basic", log0, exp_q);
      chk("basic_row", 32'(row0), 0);
      chk("basic_col", 32'(col0), 2);

      // Auto-wrap after 16 columns
      do_reset();
      for (int i = 0; i < 17; i++) push(0, 8'h78);
      wait_idle("wrap");
      exp_q.delete();
      repeat (16) exp_q.push_back(9'h078);
      exp_q.push_back(9'h1C0);
      exp_q.push_back(9'h078);
      check_log("wrap", log0, exp_q);
      chk("wrap_row", 32'(row0), 1);
      chk("wrap_col", 32'(col0), 1);

      // Control characters
      do_reset();
      for (int i = 0; i < 8; i++) push(0, ctl_str[i]);
      wait_idle("ctl");
      exp_q = '{9'h061, 9'h062, 9'h180, 9'h063, 9'h1C0, 9'h05A, 9'h101};
      check_log("ctl", log0, exp_q);
      chk("ctl_row", 32'(row0), 0);
      chk("ctl_col", 32'(col0), 0);

      // Row overflow, both wrap modes
      do_reset();
      push(0, 8'h0A); push(0, 8'h0A);
      push(1, 8'h0A); push(1, 8'h0A);
      wait_idle("rowovf");
      exp_q = '{9'h1C0, 9'h180};
      check_log("rowovf_m0", log0, exp_q);
      exp_q = '{9'h1C0, 9'h101, 9'h180};
      check_log("rowovf_m1", log1, exp_q);
      chk("rowovf_m1_row", 32'(row1), 0);
      chk("rowovf_m1_col", 32'(col1), 0);

      // Full FIFO: nothing drains while the driver is held off
      do_reset();
      init = 1'b0; hold = 1'b1;
      for (int i = 0; i < 6; i++) begin
         ch = 8'h31 + 8'(i); print0 = 1'b1;
         @(posedge clk); #1;
         if (i == 3) begin
            chk("full_busy4", 32'(busy0), 1);
            chk("full_ovf4", 32'(ovf0), 0);
         end
      end
      print0 = 1'b0;
      chk("full_busy6", 32'(busy0), 1);
      chk("full_ovf6", 32'(ovf0), 1);
      chk("full_idle", 32'(idle0), 0);
      init = 1'b1;
      repeat (5) @(posedge clk); #1;
      chk("full_no_req", 32'(log0.size()), 0);
      hold = 1'b0;
      wait_idle("full");
      exp_q = '{9'h031, 9'h032, 9'h033, 9'h034};
      check_log("full", log0, exp_q);
      chk("full_ovf_sticky", 32'(ovf0), 1);
      chk("full_busy_end", 32'(busy0), 0);

      // Reset while waiting for the driver acknowledge
      do_reset();
      push(0, 8'h41); push(0, 8'h42); push(0, 8'h43);
      begin
         int t = 0;
         while (!wd0 && t < 50) begin @(posedge clk); #1; t++; end
         chk("mid_found_req", 32'(wd0), 1);
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_wr_char", 32'(wd0), 0);
      chk("mid_wr_cmd", 32'(wc0), 0);
      chk("mid_data", 32'(data0), 0);
      chk("mid_idle", 32'(idle0), 1);
      chk("mid_busy", 32'(busy0), 0);
      chk("mid_col", 32'(col0), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      log0.delete();
      repeat (30) @(posedge clk); #1;
      chk("mid_no_req", 32'(log0.size()), 0);
      chk("mid_idle_after", 32'(idle0), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
